// File: rtl/logic16_arbiter_pkg.sv
// Shared definitions for the two-requester bitwise logic arbiter.
// Holds the opcode encodings used by the requesters and the arbiter FSM state encoding.
// No logic lives here. The LOGIC16_ARB_XOR_EN macro is consumed by logic16_unit, not by this package.
package logic16_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/logic16_unit.sv
// Bitwise operation unit: (op, a, b) -> (y, illegal), purely combinational.
// Latency: 0 cycles; the arbiter registers the outputs.
// No backpressure. Macro LOGIC16_ARB_XOR_EN makes op 11 a legal XOR; otherwise op 11 gives y=0, illegal=1.
module logic16_unit import logic16_arbiter_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             illegal
);

  // Select the bitwise function; b is a don't-care for NOT.
  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (op)
      OP_NOT: y = ~a;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: begin
`ifdef LOGIC16_ARB_XOR_EN
        y = a ^ b;
`else
        y       = '0;
        illegal = 1'b1;
`endif
      end
      default: begin
        y       = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters (IDLE -> EXEC -> DONE).
// Latency: req seen in IDLE at edge N -> done pulse in the cycle after edge N+1; one operation per 3 cycles.
// Backpressure: a requester holds req until its done pulse; a loser simply stays pending. Option: LOGIC16_ARB_XOR_EN.
module logic16_arbiter import logic16_arbiter_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);

  state_t           state;
  logic             ptr;      // index of the last requester granted
  logic             gnt;      // index of the requester currently being served
  op_t              op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             win;
  logic [WIDTH-1:0] unit_y;
  logic             unit_illegal;

  // Contest winner: on a tie the requester not granted last time wins; a sole requester always wins.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = ~ptr;
    else              win = req1;
  end

  logic16_unit #(.WIDTH(WIDTH)) u_unit (
    .op      (op_r),
    .a       (a_r),
    .b       (b_r),
    .y       (unit_y),
    .illegal (unit_illegal)
  );

  // FSM with registered outputs: capture the winner, compute, then pulse done for one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= 1'b1;
      gnt    <= 1'b0;
      op_r   <= OP_NOT;
      a_r    <= '0;
      b_r    <= '0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      result <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt   <= win;
            op_r  <= win ? op_t'(op1) : op_t'(op0);
            a_r   <= win ? a1 : a0;
            b_r   <= win ? b1 : b0;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          result <= unit_y;
          err    <= unit_illegal;
          done0  <= ~gnt;
          done1  <= gnt;
          state  <= DONE;
        end
        DONE: begin
          done0  <= 1'b0;
          done1  <= 1'b0;
          result <= '0;
          err    <= 1'b0;
          busy   <= 1'b0;
          ptr    <= gnt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic16_arbiter.sv
// Self-checking bench for logic16_arbiter: directed vector table, corner-case sequences, random vs reference model.
// Inputs are driven right after the falling edge; outputs are sampled on the falling edge.
// Honours LOGIC16_ARB_XOR_EN the same way the design does.
module tb_logic16_arbiter;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [1:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         done0, done1, err, busy;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  logic16_arbiter #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .op0    (op0),
    .op1    (op1),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .err    (err),
    .busy   (busy)
  );

  typedef struct {
    int          k;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        er;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected output bundle {done0, done1, busy, err, result}.
  function automatic logic [31:0] vec(input logic d0, input logic d1, input logic bz,
                                      input logic e, input logic [15:0] r);
    return {12'b0, d0, d1, bz, e, r};
  endfunction

  function automatic logic [31:0] outs();
    return {12'b0, done0, done1, busy, err, result};
  endfunction

  // Reference semantics of one operation: returns {err, y}.
  function automatic logic [16:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'd0:    return {1'b0, ~a};
      2'd1:    return {1'b0, a & b};
      2'd2:    return {1'b0, a | b};
      default: begin
`ifdef LOGIC16_ARB_XOR_EN
        return {1'b0, a ^ b};
`else
        return {1'b1, 16'h0000};
`endif
      end
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 2'd0; op1 = 2'd0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // One sole request from requester k; checks busy, done timing, result and return to idle.
  task automatic run_single(input string name, input int k, input logic [1:0] op,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] res, input logic er);
    if (k == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else        begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    @(negedge clock);
    check({name, "_exec"}, outs(), vec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0));
    @(negedge clock);
    check({name, "_done"}, outs(), vec(k == 0, k == 1, 1'b1, er, res));
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
    check({name, "_idle"}, outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
  endtask

  initial begin
    int   g[8];
    int   ng;
    bit   re0, re1;
    int   m_phase, m_last, m_g;
    logic [15:0] m_res;
    logic m_err;
    logic [31:0] exp_o;

    tbl[0] = '{0, 2'd0, 16'hAAAA, 16'h1234, 16'h5555, 1'b0};
    tbl[1] = '{1, 2'd1, 16'hFF00, 16'h0F0F, 16'h0F00, 1'b0};
    tbl[2] = '{0, 2'd2, 16'h1234, 16'h0001, 16'h1235, 1'b0};
`ifdef LOGIC16_ARB_XOR_EN
    tbl[3] = '{1, 2'd3, 16'h3CC3, 16'hFFFF, 16'hC33C, 1'b0};
`else
    tbl[3] = '{1, 2'd3, 16'h3CC3, 16'hFFFF, 16'h0000, 1'b1};
`endif
    tbl[4] = '{0, 2'd0, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[5] = '{1, 2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[6] = '{0, 2'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[7] = '{1, 2'd0, 16'h8001, 16'h0000, 16'h7FFE, 1'b0};

    // Reset state.
    do_reset();
    check("reset_state", outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
    @(negedge clock);
    check("idle_no_req", outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0));

    // Vector table, alternating requesters.
    for (int i = 0; i < 8; i++) begin
      run_single($sformatf("tbl%0d", i), tbl[i].k, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].er);
    end

    // Simultaneous requests: req0 wins first after reset, req1 follows three cycles later.
    do_reset();
    req0 = 1'b1; op0 = 2'd1; a0 = 16'hFF00; b0 = 16'h0F0F;
    req1 = 1'b1; op1 = 2'd2; a1 = 16'h1234; b1 = 16'h0001;
    @(negedge clock);
    check("both_exec0", outs(), vec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0));
    @(negedge clock);
    check("both_done0", outs(), vec(1'b1, 1'b0, 1'b1, 1'b0, 16'h0F00));
    req0 = 1'b0;
    @(negedge clock);
    check("both_gap", outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
    @(negedge clock);
    check("both_exec1", outs(), vec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0));
    @(negedge clock);
    check("both_done1", outs(), vec(1'b0, 1'b1, 1'b1, 1'b0, 16'h1235));
    req1 = 1'b0;
    @(negedge clock);
    check("both_idle", outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0));

    // Continuous re-requests from both sides: grants must alternate.
    do_reset();
    for (int i = 0; i < 8; i++) g[i] = -1;
    ng = 0; re0 = 1'b0; re1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1; op0 = 2'd0; op1 = 2'd2; a0 = 16'h00FF; a1 = 16'h0F00; b1 = 16'h000F;
    for (int c = 0; c < 80 && ng < 8; c++) begin
      @(negedge clock);
      if (re0) begin req0 = 1'b1; re0 = 1'b0; end
      if (re1) begin req1 = 1'b1; re1 = 1'b0; end
      if (done0) begin g[ng] = 0; ng++; req0 = 1'b0; re0 = 1'b1; end
      else if (done1) begin g[ng] = 1; ng++; req1 = 1'b0; re1 = 1'b1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_grant_count", ng, 8);
    for (int i = 0; i < 8; i++) check($sformatf("rr_grant%0d", i), g[i], i % 2);

    // Reset while in EXEC abandons the operation.
    do_reset();
    req0 = 1'b1; op0 = 2'd0; a0 = 16'h1234;
    @(negedge clock);
    check("rst_exec_busy", outs(), vec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0));
    reset = 1'b1; req0 = 1'b0;
    @(negedge clock);
    check("rst_exec_cleared", outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("rst_exec_no_done", outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
    end
    run_single("rst_after", 0, 2'd0, 16'h1234, 16'h0000, 16'hEDCB, 1'b0);

    // Operand change after capture must not disturb the in-flight result.
    req0 = 1'b1; op0 = 2'd0; a0 = 16'hFFFF; b0 = 16'h0000;
    @(negedge clock);
    check("hold_exec", outs(), vec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0));
    a0 = 16'h0000; op0 = 2'd2; b0 = 16'hFFFF;
    @(negedge clock);
    check("hold_done", outs(), vec(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000));
    req0 = 1'b0;
    @(negedge clock);
    check("hold_idle", outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0));

    // Random traffic with operands changing every cycle, checked against a transaction model.
    do_reset();
    m_phase = 0; m_last = 1; m_g = 0; m_res = '0; m_err = 1'b0;
    exp_o = vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      check("rand", outs(), exp_o);
      reset = ($urandom_range(0, 79) == 0);
      if (reset) begin
        req0 = 1'b0; req1 = 1'b0;
      end else begin
        if (done0) req0 = 1'b0;
        else if (!req0 && $urandom_range(0, 2) == 0) req0 = 1'b1;
        if (done1) req1 = 1'b0;
        else if (!req1 && $urandom_range(0, 2) == 0) req1 = 1'b1;
      end
      op0 = 2'($urandom_range(0, 3)); a0 = 16'($urandom); b0 = 16'($urandom);
      op1 = 2'($urandom_range(0, 3)); a1 = 16'($urandom); b1 = 16'($urandom);
      // Predict what the next rising edge produces.
      if (reset) begin
        m_phase = 0; m_last = 1;
        exp_o = vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      end else if (m_phase == 0) begin
        if (req0 || req1) begin
          m_g = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
          {m_err, m_res} = (m_g == 1) ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
          m_phase = 1;
          exp_o = vec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        end else begin
          exp_o = vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
        exp_o = vec(m_g == 0, m_g == 1, 1'b1, m_err, m_res);
      end else begin
        m_last = m_g;
        m_phase = 0;
        exp_o = vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic16_arbiter.md
LOGIC16_ARBITER -- requirements
Module: logic16_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result bit width; all data ports SHALL use it.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 req0, req1  input  1 each  request from requester 0/1; held high until that requester's done pulse.
REQ-005 op0, op1  input  2 each  opcode: 00 NOT a, 01 AND, 10 OR, 11 XOR.
REQ-006 a0, b0, a1, b1  input  WIDTH each  operands; b ignored for NOT.
REQ-007 done0, done1  output  1 each  one-cycle pulse: result for that requester is valid.
REQ-008 result  output  WIDTH  shared result bus, valid only while done0 or done1 is high.
REQ-009 err  output  1  high with the done pulse when the opcode was illegal.
REQ-010 busy  output  1  high in EXEC and DONE.

Function
REQ-011 FSM states: IDLE, EXEC, DONE; IDLE->EXEC when any req is high; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-012 In IDLE with a request pending: register grant index, opcode, a, b of the winner; the loser's inputs are not captured.
REQ-013 Arbitration: round-robin; pointer holds last-granted index (reset value 1, so req0 wins first contest); with both req high the non-last requester wins; a sole requester always wins.
REQ-014 In EXEC: compute the registered op on registered operands and register the result and err at the end of the cycle.
REQ-015 In DONE: assert done of the granted requester for exactly one cycle with result and err; update pointer to the granted index.
REQ-016 Latency: req high in IDLE at edge N -> done at cycle after edge N+1; back in IDLE after edge N+2; one operation per 3 cycles maximum.
REQ-017 Requester SHALL drop req in the cycle after its done; a req still high in IDLE is a new request.
REQ-018 Operand changes after capture SHALL NOT affect the in-flight result.
REQ-019 result SHALL be 0 and err 0 whenever no done is asserted.
REQ-020 Width rule: all operations bitwise over WIDTH bits; no carry, no sign.

Reset
REQ-021 reset forces state IDLE, done0=done1=0, result=0, err=0, busy=0, pointer=1, captured registers 0.
REQ-022 reset asserted in EXEC or DONE abandons the operation; no done pulse is emitted for it.
REQ-023 reset has priority over all other inputs in the same cycle.

Configuration
REQ-024 Macro LOGIC16_ARB_XOR_EN defined: op 11 computes a XOR b, err always 0.
REQ-025 Macro not defined: op 11 is illegal; done still pulses after normal latency with result=0 and err=1.

Structure
REQ-026 Shared package holds opcode constants (OP_NOT, OP_AND, OP_OR, OP_XOR) and FSM state encodings.
REQ-027 One sub-module logic16_unit: combinational, (op, a, b) -> (y, illegal), built from the existing 16-bit gate primitives; arbiter registers its outputs.

Verification
REQ-028 Reset then req0=1, op0=00, a0=16'hAAAA -> done0 pulse 2 cycles later, result=16'h5555, err=0, done1 stays 0.
REQ-029 req0 and req1 high same cycle, op0=01 a0=16'hFF00 b0=16'h0F0F, op1=10 a1=16'h1234 b1=16'h0001 -> done0 with 16'h0F00 first, then done1 with 16'h1235 three cycles later.
REQ-030 Both requesters continuously re-request 4 times -> grants alternate 0,1,0,1; no requester starved.
REQ-031 op1=11 a1=16'h3CC3 b1=16'hFFFF -> with macro: result 16'hC33C, err=0; without: result 16'h0000, err=1.
REQ-032 reset pulsed while busy in EXEC -> no done pulse, busy=0 next cycle, next req0 granted normally.
REQ-033 a0 changed to 16'h0000 in EXEC after capturing 16'hFFFF with op NOT -> result still 16'h0000 from captured value (NOT 16'hFFFF).
